// File: rtl/dp_control_sequencer.sv
// dp_control_sequencer: control stage for the register-file/ALU datapath.
// Accepts one instruction per valid/ready handshake, decodes it into register
// addresses and ALU controls, then writes the captured ALU result back two
// cycles later. Illegal ops and writes to R15 are rejected with an err pulse.
module dp_control_sequencer #(
    parameter int         DATA_W  = 32,
    parameter int         ADDR_W  = 4,
    parameter logic [2:0] MLA_OP  = 3'b110,
    parameter logic [2:0] ILLEGAL = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] ALUResult,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    output logic [ADDR_W-1:0] RA3,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic              RegWrite,
    output logic [2:0]        ALUControl,
    output logic              MLA_Select,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rn_q, rn_d;
    logic [ADDR_W-1:0]   rm_q, rm_d;
    logic [ADDR_W-1:0]   ra_q, ra_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                mla_q, mla_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                regwrite_q, regwrite_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                legal;

    // Instruction bits outside the decoded fields carry no meaning here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:28], instr[24:20], instr[7:4]};

    // An instruction may write back only if its op is implemented and it does not target R15.
    assign legal = (op_q != ILLEGAL) && (rd_q != {ADDR_W{1'b1}});

    // Next-state, instruction latch, write-back capture and pulse generation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rn_d       = rn_q;
        rm_d       = rm_q;
        ra_d       = ra_q;
        rd_d       = rd_q;
        mla_d      = mla_q;
        wd_d       = wd_q;
        result_d   = result_q;
        regwrite_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = instr[27:25];
                    rn_d    = instr[16 +: ADDR_W];
                    rd_d    = instr[12 +: ADDR_W];
                    ra_d    = instr[8 +: ADDR_W];
                    rm_d    = instr[0 +: ADDR_W];
                    mla_d   = (instr[27:25] == MLA_OP);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (legal) begin
                    wd_d       = ALUResult;
                    regwrite_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = WB;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                result_d = wd_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register; reset aborts any instruction in flight and drops RegWrite at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            ra_q       <= '0;
            rd_q       <= '0;
            mla_q      <= 1'b0;
            wd_q       <= '0;
            result_q   <= '0;
            regwrite_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            ra_q       <= ra_d;
            rd_q       <= rd_d;
            mla_q      <= mla_d;
            wd_q       <= wd_d;
            result_q   <= result_d;
            regwrite_q <= regwrite_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign RA1         = rn_q;
    assign RA2         = rm_q;
    assign RA3         = ra_q;
    assign WA          = rd_q;
    assign WD          = wd_q;
    assign ALUControl  = op_q;
    assign MLA_Select  = mla_q;
    assign RegWrite    = regwrite_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;

endmodule

// File: tb/tb_dp_control_sequencer.sv
// tb_dp_control_sequencer: directed bench with a small register-file/ALU model
// standing in for the datapath and a scoreboard of expected write-backs/rejects.
module tb_dp_control_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] ALUResult;
    logic [3:0]  RA1, RA2, RA3, WA;
    logic [31:0] WD;
    logic        RegWrite;
    logic [2:0]  ALUControl;
    logic        MLA_Select;
    logic        done;
    logic        err;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          is_err;
        logic [3:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];

    logic [31:0] rf [16] = '{32'd0, 32'd5, 32'd7, 32'd0, 32'd3, 32'd4, 32'd10, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    dp_control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ALUResult   (ALUResult),
        .RA1         (RA1),
        .RA2         (RA2),
        .RA3         (RA3),
        .WA          (WA),
        .WD          (WD),
        .RegWrite    (RegWrite),
        .ALUControl  (ALUControl),
        .MLA_Select  (MLA_Select),
        .done        (done),
        .err         (err),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: combinational ALU reading the model register file.
    always_comb begin
        ALUResult = 32'd0;
        case (ALUControl)
            3'b000: ALUResult = rf[RA1] + rf[RA2];
            3'b001: ALUResult = rf[RA1] - rf[RA2];
            3'b010: ALUResult = rf[RA1] & rf[RA2];
            3'b011: ALUResult = rf[RA1] | rf[RA2];
            3'b100: ALUResult = rf[RA1] ^ rf[RA2];
            3'b101: ALUResult = rf[RA2];
            3'b110: ALUResult = rf[RA1] * rf[RA2] + rf[RA3];
            default: ALUResult = 32'd0;
        endcase
    end

    // Register file write port driven by the sequencer.
    always @(posedge clk) begin
        if (RegWrite) rf[WA] <= WD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] rn,
                                       input logic [3:0] rm, input logic [3:0] ra,
                                       input logic [3:0] rd);
        return {4'b0, op, 5'b0, rn, rd, ra, 4'b0, rm};
    endfunction

    // Waits for ready, presents one word for one accept edge, returns #1 into EXEC.
    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Monitor: every done/err pulse pops the next expected outcome.
    always @(negedge clk) begin
        if (!reset) begin
            if (done && err) check("done_err_overlap", 32'd1, 32'd0);
            if (RegWrite && !done) check("regwrite_without_done", 32'd1, 32'd0);
            if (done || err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {31'd0, done}, {31'd0, err});
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_err", {31'd0, err}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        check("sb_wa", {28'd0, WA}, {28'd0, e.wa});
                        check("sb_wd", WD, e.wd);
                        check("sb_regwrite", {31'd0, RegWrite}, 32'd1);
                    end else begin
                        check("sb_no_regwrite", {31'd0, RegWrite}, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] words [3];
        int accepts;
        int acc_at [3];
        int n;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("rst_wd", WD, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_addr", {16'd0, RA1, RA2, RA3, WA}, 32'd0);
        check("rst_ctl", {27'd0, ALUControl, MLA_Select, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);

        // ADD R3 = R1 + R2 = 12
        sb.push_back(exp_t'{1'b0, 4'd3, 32'd12});
        send(mk(3'b000, 4'd1, 4'd2, 4'd0, 4'd3));
        check("add_ra1", {28'd0, RA1}, 32'd1);
        check("add_ra2", {28'd0, RA2}, 32'd2);
        check("add_aluctl", {29'd0, ALUControl}, 32'd0);
        check("add_ready_t1", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("add_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        check("add_ready_t2", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("add_ready_t3", {31'd0, instr_ready}, 32'd1);
        check("add_result", result, 32'd12);
        check("add_regwrite_off", {31'd0, RegWrite}, 32'd0);

        // MLA R7 = R4 * R5 + R6 = 22
        sb.push_back(exp_t'{1'b0, 4'd7, 32'd22});
        send(mk(3'b110, 4'd4, 4'd5, 4'd6, 4'd7));
        check("mla_select", {31'd0, MLA_Select}, 32'd1);
        check("mla_ra3", {28'd0, RA3}, 32'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mla_result", result, 32'd22);

        // Illegal op: err in T+2, ready already back, result unchanged
        sb.push_back(exp_t'{1'b1, 4'd0, 32'd0});
        send(mk(3'b111, 4'd1, 4'd2, 4'd0, 4'd8));
        @(posedge clk); #1;
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_done", {31'd0, done}, 32'd0);
        check("ill_ready_t2", {31'd0, instr_ready}, 32'd1);
        check("ill_result", result, 32'd22);

        // Write to R15 rejected, then R8 = R3 + R7 = 34
        sb.push_back(exp_t'{1'b1, 4'd0, 32'd0});
        send(mk(3'b000, 4'd1, 4'd2, 4'd0, 4'd15));
        sb.push_back(exp_t'{1'b0, 4'd8, 32'd34});
        send(mk(3'b000, 4'd3, 4'd7, 4'd0, 4'd8));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("r15_follow_result", result, 32'd34);

        // Reset during WB: R9 = R1 + R1 is aborted and never written
        send(mk(3'b000, 4'd1, 4'd1, 4'd0, 4'd9));
        @(posedge clk); #2;
        check("abort_wb_regwrite", {31'd0, RegWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_regwrite", {31'd0, RegWrite}, 32'd0);
        check("abort_outputs", {WD | result, 16'd0, RA1, RA2, RA3, WA}, 64'd0 >> 32);
        check("abort_ctl", {28'd0, ALUControl, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // R10 = R9 + R1 = 0 + 5, proves the aborted write never happened
        sb.push_back(exp_t'{1'b0, 4'd10, 32'd5});
        send(mk(3'b000, 4'd9, 4'd1, 4'd0, 4'd10));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post_reset_result", result, 32'd5);

        // instr_valid held for 9 cycles with 3 words: SUB 34-5, AND 12&22, XOR 12^5
        words[0] = mk(3'b001, 4'd8, 4'd1, 4'd0, 4'd11);
        words[1] = mk(3'b010, 4'd3, 4'd7, 4'd0, 4'd12);
        words[2] = mk(3'b100, 4'd3, 4'd1, 4'd0, 4'd13);
        sb.push_back(exp_t'{1'b0, 4'd11, 32'd29});
        sb.push_back(exp_t'{1'b0, 4'd12, 32'd4});
        sb.push_back(exp_t'{1'b0, 4'd13, 32'd9});
        accepts = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                if (accepts < 3) acc_at[accepts] = i;
                accepts++;
            end
            instr       = words[i / 3];
            instr_valid = 1'b1;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check("hold_accepts", accepts, 32'd3);
        check("hold_spacing1", acc_at[1], 32'd3);
        check("hold_spacing2", acc_at[2], 32'd6);
        check("hold_result", result, 32'd9);

        repeat (3) @(negedge clk);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
